// File: rtl/ram_frame_sequencer.sv
// ============================================================================
// Module   : ram_frame_sequencer
// Brief    : Read-side controller for the ping-pong RAM buffer. On each
//            buffer_ready pulse it drains DEPTH samples from the RAM read
//            port and forwards them as a framed valid/ready stream with
//            SOF/EOF markers. Counts completed frames (wrapping) and buffer
//            pulses that could not be latched (saturating).
// Options  : FRAME_HEADER_EN - prefix each frame with a header beat that
//            carries the current frame count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_frame_sequencer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   buffer_ready_i,
  input  logic [WIDTH-1:0]       ram_read_data_i,
  input  logic                   ram_read_valid_i,
  output logic                   ram_read_ready_o,
  output logic [WIDTH-1:0]       m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_sof_o,
  output logic                   m_eof_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic [FRAME_CNT_W-1:0] missed_count_o
);

  localparam int                BEAT_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
`ifdef FRAME_HEADER_EN
    ,
    ST_HDR   = 2'd3
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]       m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_sof_q, m_sof_d;
  logic                   m_eof_q, m_eof_d;
  logic                   done_q, done_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic [FRAME_CNT_W-1:0] missed_count_q, missed_count_d;

  logic                   w_out_free;   // output register can take a new beat this cycle
  logic                   w_pop;        // a RAM beat transfers this cycle
  logic                   start_frame;  // consume the pending buffer and begin a frame
`ifdef FRAME_HEADER_EN
  logic [WIDTH-1:0]       hdr_word;
`endif

  assign w_out_free       = !m_valid_q || m_ready_i;
  assign ram_read_ready_o = (state_q == ST_DRAIN) && w_out_free;
  assign w_pop            = ram_read_valid_i && ram_read_ready_o;

  // Next-state, output register, pending latch and counter update logic
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    beat_cnt_d     = beat_cnt_q;
    m_data_d       = m_data_q;
    m_valid_d      = m_valid_q;
    m_sof_d        = m_sof_q;
    m_eof_d        = m_eof_q;
    done_d         = 1'b0;
    frame_count_d  = frame_count_q;
    missed_count_d = missed_count_q;
    start_frame    = 1'b0;
`ifdef FRAME_HEADER_EN
    hdr_word                    = '0;
    hdr_word[FRAME_CNT_W-1:0]   = frame_count_q;
`endif

    // Downstream accepted the held beat; a new load below may override this.
    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q && enable_i) begin
          start_frame = 1'b1;
        end
      end
`ifdef FRAME_HEADER_EN
      ST_HDR: begin
        if (w_out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = hdr_word;
          m_sof_d   = 1'b1;
          m_eof_d   = 1'b0;
          state_d   = ST_DRAIN;
        end
      end
`endif
      ST_DRAIN: begin
        if (w_pop) begin
          m_valid_d = 1'b1;
          m_data_d  = ram_read_data_i;
`ifdef FRAME_HEADER_EN
          m_sof_d   = 1'b0;
`else
          m_sof_d   = (beat_cnt_q == '0);
`endif
          m_eof_d   = (beat_cnt_q == C_LAST_BEAT);
          if (beat_cnt_q == C_LAST_BEAT) begin
            state_d = ST_FLUSH;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // The EOF beat is gone (or leaving now): the frame is delivered.
        if (w_out_free) begin
          done_d        = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
          if (pending_q && enable_i) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_frame) begin
      pending_d  = 1'b0;
      beat_cnt_d = '0;
`ifdef FRAME_HEADER_EN
      state_d    = ST_HDR;
`else
      state_d    = ST_DRAIN;
`endif
    end

    // A pulse arriving in the same cycle the pending buffer is consumed
    // sees an empty latch and is kept rather than counted as missed.
    if (buffer_ready_i) begin
      if (enable_i && !(pending_q && !start_frame)) begin
        pending_d = 1'b1;
      end else if (missed_count_q != '1) begin
        missed_count_d = missed_count_q + 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      beat_cnt_q     <= '0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      m_sof_q        <= 1'b0;
      m_eof_q        <= 1'b0;
      done_q         <= 1'b0;
      frame_count_q  <= '0;
      missed_count_q <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      beat_cnt_q     <= beat_cnt_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      m_sof_q        <= m_sof_d;
      m_eof_q        <= m_eof_d;
      done_q         <= done_d;
      frame_count_q  <= frame_count_d;
      missed_count_q <= missed_count_d;
    end
  end

  assign m_data_o       = m_data_q;
  assign m_valid_o      = m_valid_q;
  assign m_sof_o        = m_sof_q;
  assign m_eof_o        = m_eof_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign frame_count_o  = frame_count_q;
  assign missed_count_o = missed_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_frame_sequencer.sv
// ============================================================================
// Module   : tb_ram_frame_sequencer
// Brief    : Self-checking bench for ram_frame_sequencer. A reference model
//            tracks every popped RAM sample in a queue and predicts the
//            framed output stream (data, SOF, EOF, frame count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_frame_sequencer;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 16;
  localparam int FCW    = 8;
`ifdef FRAME_HEADER_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif
  localparam int FRAME_BEATS = DEPTH + HDR_BEATS;
  localparam int RAND_FRAMES = 270;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             enable_i = 1'b0;
  logic             buffer_ready_i = 1'b0;
  logic [WIDTH-1:0] ram_read_data_i = 16'h0100;
  logic             ram_read_valid_i = 1'b0;
  logic             ram_read_ready_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i = 1'b0;
  logic             m_sof_o;
  logic             m_eof_o;
  logic             busy_o;
  logic             done_o;
  logic [FCW-1:0]   frame_count_o;
  logic [FCW-1:0]   missed_count_o;

  ram_frame_sequencer #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .FRAME_CNT_W (FCW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .buffer_ready_i   (buffer_ready_i),
    .ram_read_data_i  (ram_read_data_i),
    .ram_read_valid_i (ram_read_valid_i),
    .ram_read_ready_o (ram_read_ready_o),
    .m_data_o         (m_data_o),
    .m_valid_o        (m_valid_o),
    .m_ready_i        (m_ready_i),
    .m_sof_o          (m_sof_o),
    .m_eof_o          (m_eof_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .frame_count_o    (frame_count_o),
    .missed_count_o   (missed_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] exp_q[$];     // samples popped from RAM, not yet delivered
  int               out_pos    = 0;  // beat position inside current output frame
  int               frames_out = 0;  // frames fully delivered since reset
  int               dones      = 0;  // done pulses seen in total
  // Stimulus knobs
  int               rdy_mode   = 0;  // 0: always ready, 1: toggle, 2: random
  int               rv_mode    = 0;  // 0: RAM always valid, 1: random
  bit               tog        = 1'b1;
  bit               ram_rand   = 1'b0;
  bit               pop_pend   = 1'b0;
  logic             en_v       = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, then observe what the next
  // rising edge will do and advance the model accordingly.
  task automatic tick(input logic br, input logic rs);
    logic [WIDTH-1:0] e_data;
    bit               have;
    @(negedge clk_i);
    if (pop_pend) begin
      ram_read_data_i = ram_rand ? WIDTH'($urandom) : ram_read_data_i + 16'd1;
      pop_pend = 1'b0;
    end
    rst_i          = rs;
    buffer_ready_i = br;
    enable_i       = en_v;
    case (rdy_mode)
      0:       m_ready_i = 1'b1;
      1:       begin m_ready_i = tog; tog = !tog; end
      default: m_ready_i = ($urandom_range(0, 1) == 1);
    endcase
    ram_read_valid_i = (rv_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    if (ram_read_valid_i && ram_read_ready_o) pop_pend = 1'b1;
    if (rs) begin
      exp_q.delete();
      out_pos    = 0;
      frames_out = 0;
    end else begin
      if (m_valid_o) begin
        have   = 1'b1;
        e_data = '0;
        if (out_pos < HDR_BEATS) begin
          e_data = WIDTH'(frames_out % 256);
        end else if (exp_q.size() == 0) begin
          check("underrun", 32'd1, 32'd0);
          have = 1'b0;
        end else begin
          e_data = exp_q[0];
        end
        if (have) begin
          check("data", m_data_o, e_data);
          check("sof", m_sof_o, (out_pos == 0));
          check("eof", m_eof_o, (out_pos == FRAME_BEATS - 1));
        end
        if (m_ready_i) begin
          if (have && out_pos >= HDR_BEATS) void'(exp_q.pop_front());
          out_pos++;
          if (out_pos == FRAME_BEATS) begin
            out_pos = 0;
            frames_out++;
          end
        end else begin
          check("rd_rdy_stall", ram_read_ready_o, 32'd0);
        end
      end
      if (ram_read_valid_i && ram_read_ready_o) exp_q.push_back(ram_read_data_i);
      if (done_o) begin
        dones++;
        check("frame_cnt_at_done", frame_count_o, frames_out % 256);
      end
    end
  endtask

  task automatic run_until_done(input int target, input int budget);
    int n = 0;
    while (dones < target && n < budget) begin
      tick(1'b0, 1'b0);
      n++;
    end
    if (dones < target) check("done_timeout", dones, target);
  endtask

  task automatic run_until_pos(input int pos, input int budget);
    int n = 0;
    while (out_pos != pos && n < budget) begin
      tick(1'b0, 1'b0);
      n++;
    end
    if (out_pos != pos) check("beat_timeout", out_pos, pos);
  endtask

  initial begin
    int d0;

    // Reset held for three cycles; everything must read zero afterwards.
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("rst_valid",  m_valid_o, 0);
    check("rst_data",   m_data_o, 0);
    check("rst_sof",    m_sof_o, 0);
    check("rst_eof",    m_eof_o, 0);
    check("rst_busy",   busy_o, 0);
    check("rst_done",   done_o, 0);
    check("rst_fcnt",   frame_count_o, 0);
    check("rst_missed", missed_count_o, 0);
    check("rst_rdrdy",  ram_read_ready_o, 0);

    // Single frame, full throughput, counting data 0x0100..
    en_v = 1'b1;
    d0 = dones;
    tick(1'b1, 1'b0);
    run_until_done(d0 + 1, 200);
    check("t2_fcnt", frame_count_o, 1);
    check("t2_dones", dones - d0, 1);

    // Toggled backpressure
    ram_read_data_i = 16'h0200;
    rdy_mode = 1;
    d0 = dones;
    tick(1'b1, 1'b0);
    run_until_done(d0 + 1, 300);
    check("t3_fcnt", frame_count_o, 2);
    rdy_mode = 0;

    // Pulses at start, +4 and +8: second pends, third is missed
    d0 = dones;
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    run_until_done(d0 + 2, 300);
    repeat (3) tick(1'b0, 1'b0);
    check("t4_missed", missed_count_o, 1);
    check("t4_fcnt", frame_count_o, 4);
    check("t4_busy", busy_o, 0);

    // Pulse with enable low is dropped and counted
    en_v = 1'b0;
    tick(1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b0);
    check("t5_missed", missed_count_o, 2);
    check("t5_fcnt_idle", frame_count_o, 4);
    check("t5_busy_idle", busy_o, 0);

    // Enable dropped mid-frame: the frame still completes
    en_v = 1'b1;
    d0 = dones;
    tick(1'b1, 1'b0);
    run_until_pos(5, 100);
    en_v = 1'b0;
    run_until_done(d0 + 1, 200);
    repeat (5) tick(1'b0, 1'b0);
    check("t5_fcnt", frame_count_o, 5);
    check("t5_busy", busy_o, 0);

    // Reset in the middle of a frame, then a clean restart
    en_v = 1'b1;
    tick(1'b1, 1'b0);
    run_until_pos(7, 100);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("t6_valid", m_valid_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_fcnt", frame_count_o, 0);
    check("t6_missed", missed_count_o, 0);
    ram_read_data_i = 16'h0300;
    d0 = dones;
    tick(1'b1, 1'b0);
    run_until_done(d0 + 1, 200);
    check("t6_fcnt_after", frame_count_o, 1);

    // Missed counter saturation
    en_v = 1'b0;
    repeat (260) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
    check("sat_missed", missed_count_o, 255);

    // Randomised data, RAM stalls and backpressure across a frame-count wrap
    en_v     = 1'b1;
    ram_rand = 1'b1;
    rv_mode  = 1;
    rdy_mode = 2;
    for (int f = 0; f < RAND_FRAMES; f++) begin
      d0 = dones;
      tick(1'b1, 1'b0);
      run_until_done(d0 + 1, 3000);
    end
    repeat (4) tick(1'b0, 1'b0);
    check("rand_fcnt", frame_count_o, (1 + RAND_FRAMES) % 256);
    check("rand_missed_hold", missed_count_o, 255);
    check("rand_busy", busy_o, 0);
    check("rand_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
